execute_exmem_unit: RTL and testbench



---
 rtl/execute_exmem_unit_pkg.sv | 45 ++++
 rtl/execute_exmem_unit_if.sv | 36 +++
 rtl/execute_exmem_unit_forward_sel.sv | 19 +
 rtl/execute_exmem_unit.sv | 92 +++++++++
 tb/tb_execute_exmem_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/execute_exmem_unit_pkg.sv
// Shared constants for the execute stage: ALU control codes, forward-select
// encodings and the ALU control decoder.
package execute_exmem_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // funct7b5 only means SUB for register-register ops; with an immediate it is imm bits.
  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5,
                                            input logic       alu_src);
    logic [3:0] code;
    code = ALU_ADD;
    case (alu_op)
      2'b01: code = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000: code = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
          3'b111: code = ALU_AND;
          3'b110: code = ALU_OR;
          3'b100: code = ALU_XOR;
          3'b001: code = ALU_SLL;
          3'b101: code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b010: code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/execute_exmem_unit_if.sv
// ID/EX, forwarding and EX/MEM signal bundle of the execute stage.
interface execute_exmem_unit_if #(parameter int XLEN = 64);
  logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]      alu_op;
  logic            reg_write_mem_wb;
  logic [4:0]      rd_mem_wb;
  logic [XLEN-1:0] wb_data;
  logic [1:0]      forward_a, forward_b;
  logic [3:0]      alu_ctrl;
  logic            mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3;
  logic [XLEN-1:0] pc_branch_d3, alu_result_d3, rs2_data_d3;
  logic            alu_zero_d3;
  logic [4:0]      rd_d3;

  modport master (
    output pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7b5,
           branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           reg_write_mem_wb, rd_mem_wb, wb_data,
    input  forward_a, forward_b, alu_ctrl,
           mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3,
           pc_branch_d3, alu_result_d3, rs2_data_d3, alu_zero_d3, rd_d3
  );

  modport slave (
    input  pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7b5,
           branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           reg_write_mem_wb, rd_mem_wb, wb_data,
    output forward_a, forward_b, alu_ctrl,
           mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3,
           pc_branch_d3, alu_result_d3, rs2_data_d3, alu_zero_d3, rd_d3
  );
endinterface

// File: rtl/execute_exmem_unit_forward_sel.sv
// Forward-select for one source register; the younger EX/MEM producer wins.
module forward_sel
  import execute_exmem_unit_pkg::*;
(
  input  logic       reg_write_mem,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_wb,
  input  logic [4:0] rd_wb,
  input  logic [4:0] rs,
  output logic [1:0] sel
);
  always_comb begin
    sel = FWD_NONE;
    if (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs)
      sel = FWD_MEM;
    else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs)
      sel = FWD_WB;
  end
endmodule

// File: rtl/execute_exmem_unit.sv
// Execute stage: operand forwarding, ALU, branch target and the EX/MEM register.
module execute_exmem_unit
  import execute_exmem_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic                 clk,
  input logic                 rst,
  execute_exmem_unit_if.slave bus
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][4:0]      rs_idx;
  logic [NUM_SRC-1:0][1:0]      fwd_sel;
  logic [NUM_SRC-1:0][XLEN-1:0] rs_val, src_val;
  logic [XLEN-1:0]              op_a, op_b, alu_y, pc_branch;
  logic [3:0]                   alu_ctrl;

  assign rs_idx = {bus.rs2, bus.rs1};
  assign rs_val = {bus.rs2_data, bus.rs1_data};

  // Source 0 is rs1, source 1 is rs2; the unused 11 encoding falls back to the register file.
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      forward_sel u_fwd (
        .reg_write_mem (bus.reg_write_d3),
        .rd_mem        (bus.rd_d3),
        .reg_write_wb  (bus.reg_write_mem_wb),
        .rd_wb         (bus.rd_mem_wb),
        .rs            (rs_idx[i]),
        .sel           (fwd_sel[i])
      );
      assign src_val[i] = (fwd_sel[i] == FWD_MEM) ? bus.alu_result_d3 :
                          (fwd_sel[i] == FWD_WB)  ? bus.wb_data       : rs_val[i];
    end
  endgenerate

  assign bus.forward_a = fwd_sel[0];
  assign bus.forward_b = fwd_sel[1];

  assign alu_ctrl     = alu_decode(bus.alu_op, bus.funct3, bus.funct7b5, bus.alu_src);
  assign bus.alu_ctrl = alu_ctrl;

  assign op_a      = src_val[0];
  assign op_b      = bus.alu_src ? bus.imm : src_val[1];
  assign pc_branch = bus.pc + (bus.imm << 1);

  always_comb begin
    alu_y = '0;
    case (alu_ctrl)
      ALU_ADD: alu_y = op_a + op_b;
      ALU_SUB: alu_y = op_a - op_b;
      ALU_AND: alu_y = op_a & op_b;
      ALU_OR:  alu_y = op_a | op_b;
      ALU_XOR: alu_y = op_a ^ op_b;
      ALU_SLL: alu_y = op_a << op_b[5:0];
      ALU_SRL: alu_y = op_a >> op_b[5:0];
      ALU_SRA: alu_y = $signed(op_a) >>> op_b[5:0];
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_y = '0;
    endcase
  end

  // Store data is the forwarded rs2, taken before the immediate mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_to_reg_d3 <= 1'b0;
      bus.reg_write_d3  <= 1'b0;
      bus.branch_d3     <= 1'b0;
      bus.mem_read_d3   <= 1'b0;
      bus.mem_write_d3  <= 1'b0;
      bus.pc_branch_d3  <= '0;
      bus.alu_result_d3 <= '0;
      bus.rs2_data_d3   <= '0;
      bus.alu_zero_d3   <= 1'b0;
      bus.rd_d3         <= 5'd0;
    end else begin
      bus.mem_to_reg_d3 <= bus.mem_to_reg;
      bus.reg_write_d3  <= bus.reg_write;
      bus.branch_d3     <= bus.branch;
      bus.mem_read_d3   <= bus.mem_read;
      bus.mem_write_d3  <= bus.mem_write;
      bus.pc_branch_d3  <= pc_branch;
      bus.alu_result_d3 <= alu_y;
      bus.rs2_data_d3   <= src_val[1];
      bus.alu_zero_d3   <= (alu_y == '0);
      bus.rd_d3         <= bus.rd;
    end
  end

endmodule

// File: tb/tb_execute_exmem_unit.sv
// Random and directed stimulus against a behavioural model of the execute stage.
module tb_execute_exmem_unit;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [63:0] pc, rs1_data, rs2_data, imm, wb_data;
    logic [4:0]  rs1, rs2, rd, rd_mem_wb;
    logic [2:0]  funct3;
    logic [1:0]  alu_op;
    logic        funct7b5, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_write_mem_wb;
  } instr_t;

  typedef struct packed {
    logic [63:0] alu, pcb, rs2d;
    logic        z;
    logic [4:0]  rd;
    logic        m2r, rw, br, mr, mw;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  st_t  st = '0;

  always #5 clk = ~clk;

  execute_exmem_unit_if #(.XLEN(XLEN)) bus ();
  execute_exmem_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".alu_result"}, bus.alu_result_d3, st.alu);
    chk({tag, ".pc_branch"},  bus.pc_branch_d3, st.pcb);
    chk({tag, ".rs2_data"},   bus.rs2_data_d3, st.rs2d);
    chk({tag, ".zero"},       64'(bus.alu_zero_d3), 64'(st.z));
    chk({tag, ".rd"},         64'(bus.rd_d3), 64'(st.rd));
    chk({tag, ".ctrl"}, 64'({bus.mem_to_reg_d3, bus.reg_write_d3, bus.branch_d3, bus.mem_read_d3, bus.mem_write_d3}),
                        64'({st.m2r, st.rw, st.br, st.mr, st.mw}));
  endtask

  task automatic drive(input instr_t t);
    bus.pc = t.pc; bus.rs1_data = t.rs1_data; bus.rs2_data = t.rs2_data; bus.imm = t.imm;
    bus.rs1 = t.rs1; bus.rs2 = t.rs2; bus.rd = t.rd; bus.funct3 = t.funct3; bus.funct7b5 = t.funct7b5;
    bus.branch = t.branch; bus.mem_read = t.mem_read; bus.mem_to_reg = t.mem_to_reg;
    bus.mem_write = t.mem_write; bus.alu_src = t.alu_src; bus.reg_write = t.reg_write; bus.alu_op = t.alu_op;
    bus.reg_write_mem_wb = t.reg_write_mem_wb; bus.rd_mem_wb = t.rd_mem_wb; bus.wb_data = t.wb_data;
  endtask

  // Newest writer of a register supplies its value: previous instruction, then write-back, then the file.
  function automatic logic [1:0] src_of(input st_t s, input instr_t t, input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (s.rw && s.rd == r) return 2'd2;
    if (t.reg_write_mem_wb && t.rd_mem_wb == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] value_of(input logic [1:0] src, input logic [63:0] file_val,
                                           input st_t s, input instr_t t);
    if (src == 2'd2) return s.alu;
    if (src == 2'd1) return t.wb_data;
    return file_val;
  endfunction

  function automatic void ref_alu(input instr_t t, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [3:0] code);
    logic [5:0] sh;
    sh = b[5:0];
    code = 4'd2; r = a + b;
    if (t.alu_op == 2'b01) begin code = 4'd6; r = a - b; end
    else if (t.alu_op == 2'b10) begin
      case (t.funct3)
        3'd0: if (t.funct7b5 && !t.alu_src) begin code = 4'd6; r = a - b; end
        3'd7: begin code = 4'd0; r = a & b; end
        3'd6: begin code = 4'd1; r = a | b; end
        3'd4: begin code = 4'd3; r = a ^ b; end
        3'd1: begin code = 4'd4; r = a << sh; end
        3'd5: if (t.funct7b5) begin code = 4'd7; r = $signed(a) >>> sh; end
              else begin code = 4'd5; r = a >> sh; end
        3'd2: begin code = 4'd8; r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; end
        default: ;
      endcase
    end
  endfunction

  task automatic step(input instr_t t);
    logic [1:0]  fa, fb;
    logic [63:0] a, bf, b, res;
    logic [3:0]  code;
    st_t         nxt;
    drive(t);
    #1;
    fa = src_of(st, t, t.rs1);
    fb = src_of(st, t, t.rs2);
    a  = value_of(fa, t.rs1_data, st, t);
    bf = value_of(fb, t.rs2_data, st, t);
    b  = t.alu_src ? t.imm : bf;
    ref_alu(t, a, b, res, code);
    chk("forward_a", 64'(bus.forward_a), 64'(fa));
    chk("forward_b", 64'(bus.forward_b), 64'(fb));
    chk("alu_ctrl",  64'(bus.alu_ctrl), 64'(code));
    nxt = '{alu: res, pcb: t.pc + (t.imm << 1), rs2d: bf, z: (res == 64'd0), rd: t.rd,
            m2r: t.mem_to_reg, rw: t.reg_write, br: t.branch, mr: t.mem_read, mw: t.mem_write};
    @(posedge clk);
    #1;
    st = nxt;
    check_regs("cap");
  endtask

  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    st = '0;
    check_regs("rst_async");
    @(posedge clk);
    #1;
    check_regs("rst_hold");
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_data();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 15));
      1: return -64'($urandom_range(1, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    t = '0;
    t.pc = {32'd0, $urandom}; t.rs1_data = rnd_data(); t.imm = rnd_data(); t.wb_data = rnd_data();
    t.rs2_data = ($urandom_range(0, 4) == 0) ? t.rs1_data : rnd_data();
    t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
    t.rd = 5'($urandom_range(0, 3)); t.rd_mem_wb = 5'($urandom_range(0, 3));
    t.funct3 = 3'($urandom); t.alu_op = 2'($urandom); t.funct7b5 = 1'($urandom);
    t.branch = 1'($urandom); t.mem_read = 1'($urandom); t.mem_to_reg = 1'($urandom);
    t.mem_write = 1'($urandom); t.alu_src = 1'($urandom); t.reg_write = 1'($urandom);
    t.reg_write_mem_wb = 1'($urandom);
    return t;
  endfunction

  instr_t t;

  initial begin
    t = '0;
    drive(t);
    repeat (2) @(posedge clk);
    #1;
    check_regs("por");
    rst = 1'b0;

    // R-type add
    t = '0; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rs1_data = 64'd5; t.rs2_data = 64'd7;
    t.alu_op = 2'b10; t.reg_write = 1'b1; t.rd = 5'd3;
    step(t);
    chk("rtype_add", bus.alu_result_d3, 64'd12);

    // branch compare
    t = '0; t.rs1 = 5'd6; t.rs2 = 5'd7; t.rs1_data = 64'd9; t.rs2_data = 64'd9;
    t.alu_op = 2'b01; t.pc = 64'h100; t.imm = 64'd8; t.branch = 1'b1;
    step(t);
    chk("branch_target", bus.pc_branch_d3, 64'h110);
    chk("branch_zero", 64'(bus.alu_zero_d3), 64'd1);

    // EX/MEM forward, without and with a competing MEM/WB match
    for (int k = 0; k < 2; k++) begin
      t = '0; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rs1_data = 64'd5; t.rs2_data = 64'd7;
      t.alu_op = 2'b10; t.reg_write = 1'b1; t.rd = 5'd5;
      step(t);
      t = '0; t.rs1 = 5'd5; t.rs2 = 5'd1; t.rs1_data = 64'd0; t.rs2_data = 64'd1;
      t.reg_write_mem_wb = (k == 1); t.rd_mem_wb = 5'd5; t.wb_data = 64'd99;
      step(t);
      chk("exmem_fwd", bus.alu_result_d3, 64'd13);
    end

    // x0 is never forwarded from either stage
    t = '0; t.rs1_data = 64'd3; t.rs2_data = 64'd4; t.rs1 = 5'd1; t.rs2 = 5'd2; t.reg_write = 1'b1;
    step(t);
    t = '0; t.rs1_data = 64'd42; t.rs2_data = 64'd1; t.reg_write_mem_wb = 1'b1; t.wb_data = 64'd77;
    step(t);
    chk("x0_guard", bus.alu_result_d3, 64'd43);

    // load/store address
    t = '0; t.rs1 = 5'd8; t.rs2 = 5'd9; t.rs1_data = 64'd100; t.imm = -64'd8; t.rs2_data = 64'd55;
    t.alu_src = 1'b1; t.mem_write = 1'b1;
    step(t);
    chk("ls_addr", bus.alu_result_d3, 64'd92);
    chk("ls_store", bus.rs2_data_d3, 64'd55);

    mid_reset();

    for (int n = 0; n < 400; n++) begin
      step(rnd_instr());
      if ($urandom_range(0, 49) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
